// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//
// Conditions raw board pushbuttons for the Avalon key PIO. Each key is
// synchronised through two flops, normalised so that 1 = pressed, and then
// debounced independently: a new level is accepted only after it has been
// seen for DEBOUNCE_CYCLES consecutive clocks. Single-cycle press/release
// strobes are produced for local logic.
//
// Optional feature (macro KEY_DEBOUNCE_LATCH_EN): adds sticky per-key press
// flags (press_latched) with a per-bit clear (latch_clr). When the macro is
// undefined those ports and their flops do not exist.
//
// Parameters:
//   WIDTH            number of keys
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a level (1..2^24)
//   ACTIVE_LOW       1: pad reads 0 when pressed; 0: pad reads 1 when pressed
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   key_in         raw asynchronous pad levels
//   key_out        debounced level, 1 = pressed (drives PIO in_port)
//   key_press      one-cycle strobe when a key_out bit rises
//   key_release    one-cycle strobe when a key_out bit falls
//   press_latched  sticky press flags            (KEY_DEBOUNCE_LATCH_EN only)
//   latch_clr      per-bit clear of press_latched (KEY_DEBOUNCE_LATCH_EN only)
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] key_in,
  output logic [WIDTH-1:0] key_out,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release
`ifdef KEY_DEBOUNCE_LATCH_EN
  ,
  output logic [WIDTH-1:0] press_latched,
  input  logic [WIDTH-1:0] latch_clr
`endif
);

  localparam int              CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Level a released pad sits at; also the polarity flip mask.
  localparam logic [WIDTH-1:0] IDLE_PAD = {WIDTH{ACTIVE_LOW}};

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] raw;     // synchronised, 1 = pressed
  logic [WIDTH-1:0] stable;  // accepted debounced level
  logic [WIDTH-1:0] accept;  // this edge commits raw into stable

  // Synchroniser resets to the idle pad level so that leaving reset never
  // looks like a press.
  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= IDLE_PAD;
      sync2 <= IDLE_PAD;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign raw = sync2 ^ IDLE_PAD;

  // Per-key mismatch counter. It counts consecutive edges on which raw differs
  // from the accepted level; any agreement restarts it, and acceptance clears
  // it, so it can never pass CNT_MAX.
  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    logic [CNT_W-1:0] cnt;

    assign accept[i] = (raw[i] != stable[i]) && (cnt == CNT_MAX);

    // NOTE: every counter is a discrete flop with an async reset; a reset in the
    // middle of a count must discard it so a held key restarts its full delay.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt <= '0;
      end else if (raw[i] == stable[i] || accept[i]) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable      <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      stable      <= stable ^ accept;
      key_press   <= accept & raw;
      key_release <= accept & ~raw;
    end
  end

  assign key_out = stable;

`ifdef KEY_DEBOUNCE_LATCH_EN
  // Set on the same edge that stable rises; set beats a coincident clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      press_latched <= '0;
    end else begin
      press_latched <= (press_latched & ~latch_clr) | (accept & raw);
    end
  end
`endif

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
//
// Scoreboard bench for key_debounce (WIDTH=4, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1).
// A driver applies one stimulus vector per clock and pushes the reference
// model's expected outputs for the following edge into a queue; a monitor pops
// one entry per edge and compares. The reference model keeps a history of
// pressed samples and accepts a new level when the last N samples seen by the
// filter (two edges late, for the synchroniser) all disagree with the current
// debounced level.
// -----------------------------------------------------------------------------
module tb_key_debounce;

  localparam int WIDTH = 4;
  localparam int N     = 4;
  localparam bit ACTIVE_LOW = 1'b1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] key_in = '1;
  logic [WIDTH-1:0] key_out;
  logic [WIDTH-1:0] key_press;
  logic [WIDTH-1:0] key_release;
  logic [WIDTH-1:0] latch_clr_v = '0;
`ifdef KEY_DEBOUNCE_LATCH_EN
  logic [WIDTH-1:0] press_latched;
`endif

  key_debounce #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(N),
    .ACTIVE_LOW(ACTIVE_LOW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .key_in(key_in),
    .key_out(key_out),
    .key_press(key_press),
    .key_release(key_release)
`ifdef KEY_DEBOUNCE_LATCH_EN
    ,
    .press_latched(press_latched),
    .latch_clr(latch_clr_v)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] press;
    logic [WIDTH-1:0] rel;
    logic [WIDTH-1:0] lat;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] hist[$];   // pressed samples per edge, index 0 = newest
  logic [WIDTH-1:0] m_level;
  logic [WIDTH-1:0] m_lat;
  int               checks = 0;
  int               failures = 0;
  bit               active = 1'b0;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_level = '0;
    m_lat   = '0;
    hist.delete();
    for (int j = 0; j < N + 2; j++) hist.push_back('0);
  endtask

  // One clock of stimulus: drive at the falling edge, predict the next rising edge.
  task automatic step(input logic rst_v, input logic [WIDTH-1:0] pad,
                      input logic [WIDTH-1:0] clr);
    exp_t             e;
    logic [WIDTH-1:0] nxt;
    bit               was_run;
    @(negedge clk);
    was_run     = reset_n;
    reset_n     = rst_v;
    key_in      = pad;
    latch_clr_v = clr;
    if (!rst_v) begin
      model_reset();
      e = '0;
      if (was_run) begin
        #1;
        check("async_reset_out", key_out, '0);
        check("async_reset_press", key_press | key_release, '0);
      end
    end else begin
      hist.push_front(ACTIVE_LOW ? ~pad : pad);
      void'(hist.pop_back());
      nxt = m_level;
      for (int i = 0; i < WIDTH; i++) begin
        bit all_differ = 1'b1;
        for (int j = 2; j <= N + 1; j++)
          if (hist[j][i] == m_level[i]) all_differ = 1'b0;
        if (all_differ) nxt[i] = ~m_level[i];
      end
      e.out   = nxt;
      e.press = nxt & ~m_level;
      e.rel   = ~nxt & m_level;
      m_lat   = (m_lat & ~clr) | e.press;
      e.lat   = m_lat;
      m_level = nxt;
    end
    exp_q.push_back(e);
    active = 1'b1;
  endtask

  // Monitor: one expected entry per rising edge, sampled 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("key_out", key_out, e.out);
        check("key_press", key_press, e.press);
        check("key_release", key_release, e.rel);
`ifdef KEY_DEBOUNCE_LATCH_EN
        check("press_latched", press_latched, e.lat);
`endif
      end else if (active) begin
        check("scoreboard_empty", 4'h1, 4'h0);
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] pad;
    logic [WIDTH-1:0] clr;
    logic             rst_v;
    int               hold[WIDTH];

    model_reset();
    // Reset, then idle pads for 20 cycles: no output, no strobes.
    repeat (3) step(1'b0, 4'hF, 4'h0);
    repeat (20) step(1'b1, 4'hF, 4'h0);

    // Key 0 pressed and held; sticky flag cleared on the very rise edge.
    repeat (5) step(1'b1, 4'hE, 4'h0);
    step(1'b1, 4'hE, 4'h1);
    repeat (4) step(1'b1, 4'hE, 4'h0);
    step(1'b1, 4'hE, 4'h1);
    step(1'b1, 4'hE, 4'h0);

    // Five back-to-back glitches on key 1, each shorter than N.
    repeat (5) begin
      repeat (3) step(1'b1, 4'hC, 4'h0);
      step(1'b1, 4'hE, 4'h0);
    end
    repeat (6) step(1'b1, 4'hE, 4'h0);

    // Key 2 held until accepted, then released.
    repeat (8) step(1'b1, 4'hA, 4'h0);
    repeat (8) step(1'b1, 4'hE, 4'h0);

    // Key 3 held, reset after two counts, still held after release.
    repeat (4) step(1'b1, 4'h6, 4'h0);
    repeat (2) step(1'b0, 4'h6, 4'h0);
    repeat (10) step(1'b1, 4'h6, 4'h0);
    repeat (8) step(1'b1, 4'hF, 4'h0);

    // Randomised phase: each pad holds a random level for 1..8 cycles.
    pad = 4'hF;
    for (int i = 0; i < WIDTH; i++) hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (hold[i] == 0) begin
          pad[i]  = 1'($urandom_range(1));
          hold[i] = $urandom_range(8, 1);
        end
        hold[i]--;
      end
      clr   = ($urandom_range(7) == 0) ? 4'($urandom) : 4'h0;
      rst_v = ($urandom_range(400) != 0);
      step(rst_v, pad, clr);
    end

    @(posedge clk);
    #2;
    active = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
